// File: rtl/ram_dp_rd_streamer_pkg.sv
// ---------------------------------------------------------------------------
// ram_rd_pkg
// Shared definitions for the dual-port RAM read streamer:
//   - rdState_e     : burst controller states
//   - RD_LATENCY_*  : the two read latencies the RAM can be built with
//                     (1 = pmi_regmode "noreg", 2 = pmi_regmode "reg")
//   - clog2()       : elaboration-time ceiling log2 used to size FIFO counters
// ---------------------------------------------------------------------------
package ram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rdState_e;

  localparam int RD_LATENCY_NOREG = 1;
  localparam int RD_LATENCY_REG   = 2;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_dp_rd_streamer_if.sv
// ---------------------------------------------------------------------------
// ram_dp_rd_streamer_if
// Valid/ready output stream of the RAM read streamer.
//   OutData  : stream word
//   OutValid : word present
//   OutReady : consumer accepts the word this cycle
//   OutLast  : word is the final beat of the burst
// modport master : the streamer (drives data/valid/last)
// modport slave  : the consumer (drives ready)
// ---------------------------------------------------------------------------
interface ram_dp_rd_streamer_if #(
  parameter int DATA_WIDTH = 18
);

  logic [DATA_WIDTH-1:0] OutData;
  logic                  OutValid;
  logic                  OutReady;
  logic                  OutLast;

  modport master (
    output OutData,
    output OutValid,
    output OutLast,
    input  OutReady
  );

  modport slave (
    input  OutData,
    input  OutValid,
    input  OutLast,
    output OutReady
  );

endinterface

// File: rtl/ram_dp_rd_streamer_fifo.sv
// ---------------------------------------------------------------------------
// ram_dp_rd_fifo
// Small synchronous register FIFO, first-word-fall-through, with a bypass:
// when storage is empty a word being pushed is already visible on popData_o,
// and if it is popped in the same cycle it is never written.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears storage too)
//   flush_i     : drop all contents (pointers/count only)
//   push_i      : write pushData_i
//   pop_i       : consume the word on popData_o
//   popData_o   : head word, or pushData_i when empty and pushing, else 0
//   count_o     : number of stored words
//   full_o      : storage holds DEPTH words
//   empty_o     : storage holds no words
// ---------------------------------------------------------------------------
module ram_dp_rd_fifo
  import ram_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic [clog2(DEPTH):0]    count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic             doWrite;
  logic             doRead;

  // A push into an empty FIFO that is popped straight away goes through
  // the bypass path and never touches storage.
  always_comb begin
    empty_o   = (count_q == '0);
    full_o    = (count_q == (PW + 1)'(DEPTH));
    count_o   = count_q;
    doWrite   = push_i && !(empty_o && pop_i);
    doRead    = pop_i && !empty_o;
    popData_o = '0;
    if (!empty_o) begin
      popData_o = mem_q[rdPtr_q];
    end else if (push_i) begin
      popData_o = pushData_i;
    end
  end

  // Storage and pointer update; flush keeps stale words but empties the
  // queue so nothing old can be presented again.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      assert (!(doWrite && full_o));
      if (doWrite) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doRead) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_dp_rd_streamer.sv
// ---------------------------------------------------------------------------
// ram_dp_rd_streamer
// Read-side client for pmi_ram_dp: takes a burst command, walks the RAM read
// port one address per clock, absorbs the RAM read latency with a valid-tag
// pipeline, and presents the words as a valid/ready stream.
// Optional macro RD_STREAMER_ABORT_EN adds the Abort input (flush and end
// the burst early, still pulsing Done once).
// Ports:
//   Clock, Reset : single clock, synchronous active-high reset
//   Start        : command strobe, honoured only in IDLE
//   StartAddr    : first read address
//   Length       : word count, 0..2**ADDR_WIDTH
//   Busy, Done   : burst in progress / one-cycle completion pulse
//   RdAddress    : RAM read address (registered)
//   RdClockEn    : RAM read clock enable
//   RamQ         : RAM read data
//   Abort        : (macro only) abandon the running burst
//   outStream    : output stream (master modport)
// ---------------------------------------------------------------------------
module ram_dp_rd_streamer
  import ram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 18,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartAddr,
  input  logic [ADDR_WIDTH:0]   Length,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] RdAddress,
  output logic                  RdClockEn,
  input  logic [DATA_WIDTH-1:0] RamQ,
`ifdef RD_STREAMER_ABORT_EN
  input  logic                  Abort,
`endif
  ram_dp_rd_streamer_if.master  outStream
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] LEN_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CW:0]         CREDIT_ONE = {{CW{1'b0}}, 1'b1};
  localparam logic [CW:0]         CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  rdState_e              state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   issueCnt_q;
  logic [ADDR_WIDTH:0]   beatCnt_q;
  logic [RD_LATENCY-1:0] tagValid_q, tagValid_d;
  logic [RD_LATENCY-1:0] tagLast_q, tagLast_d;
  logic                  busy_q;
  logic                  done_q;
  logic                  rdClockEn_q;

  logic [CW-1:0]         fifoCount;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  fifoPush;
  logic                  fifoPop;
  logic [DATA_WIDTH:0]   fifoOut;
  logic [CW:0]           inflight;
  logic [CW:0]           creditSum;
  logic                  issueNow;
  logic                  handshake;
  logic                  abortNow;
  logic                  outValid;

`ifdef RD_STREAMER_ABORT_EN
  assign abortNow = Abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
`else
  assign abortNow = 1'b0;
`endif

  // Credit: every read either still in the RAM pipeline or already buffered
  // owns a FIFO slot, so a tag emerging can always be stored even if the
  // consumer stalls indefinitely.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {{CW{1'b0}}, tagValid_q[i]};
    end
    creditSum = inflight + {1'b0, fifoCount} + CREDIT_ONE;
    issueNow  = (state_q == ST_ISSUE) && (creditSum <= CREDIT_MAX) &&
                !fifoFull && !abortNow;
    fifoPush  = tagValid_q[RD_LATENCY-1];
    outValid  = !fifoEmpty || fifoPush;
    handshake = outValid && outStream.OutReady;
    fifoPop   = handshake;
  end

  // Tag pipeline mirrors the RAM read pipeline; the last-beat flag travels
  // alongside so OutLast comes out with exactly the final word.
  always_comb begin
    tagValid_d = '0;
    tagLast_d  = '0;
    if (!abortNow) begin
      tagValid_d[0] = issueNow;
      tagLast_d[0]  = issueNow && (issueCnt_q == LEN_ONE);
      for (int i = 1; i < RD_LATENCY; i++) begin
        tagValid_d[i] = tagValid_q[i-1];
        tagLast_d[i]  = tagLast_q[i-1];
      end
    end
  end

  // Burst controller. Outputs are registered alongside the state so Busy,
  // Done and RdClockEn change on the same edge as the state they describe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issueCnt_q  <= '0;
      beatCnt_q   <= '0;
      tagValid_q  <= '0;
      tagLast_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdClockEn_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      tagValid_q <= tagValid_d;
      tagLast_q  <= tagLast_d;
      if (handshake) begin
        beatCnt_q <= beatCnt_q - LEN_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (Length != '0) begin
              state_q     <= ST_ISSUE;
              addr_q      <= StartAddr;
              issueCnt_q  <= Length;
              beatCnt_q   <= Length;
              busy_q      <= 1'b1;
              rdClockEn_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (abortNow) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            rdClockEn_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (issueNow) begin
            addr_q     <= addr_q + 1'b1;
            issueCnt_q <= issueCnt_q - LEN_ONE;
            if (issueCnt_q == LEN_ONE) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abortNow || (handshake && (beatCnt_q == LEN_ONE))) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            rdClockEn_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  ram_dp_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .flush_i    (abortNow),
    .push_i     (fifoPush),
    .pushData_i ({tagLast_q[RD_LATENCY-1], RamQ}),
    .pop_i      (fifoPop),
    .popData_o  (fifoOut),
    .count_o    (fifoCount),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign Busy               = busy_q;
  assign Done               = done_q;
  assign RdAddress          = addr_q;
  assign RdClockEn          = rdClockEn_q;
  assign outStream.OutValid = outValid;
  assign outStream.OutData  = fifoOut[DATA_WIDTH-1:0];
  assign outStream.OutLast  = fifoOut[DATA_WIDTH];

endmodule
